// File: rtl/ram_fifo_pkg.sv
// Shared sizing helpers for the RAM-backed first-word-fall-through FIFO.
// Holds the output-stage depth and the occupancy counter width function.
package ram_fifo_pkg;

    localparam int OUT_STAGE_DEPTH = 2;
    localparam int OCC_W           = $clog2(OUT_STAGE_DEPTH + 1);

    // Wide enough for DEPTH RAM entries plus the in-flight read and output stage.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/mem_dual_port_rw.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// WRITE_FIRST forwards same-address write data to the read port; INIT!=0 zeroes idle reads.
module mem_dual_port_rw #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int WRITE_FIRST = 1,
    parameter int INIT        = 0
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (INIT != 0) begin
            rdata_d = '0;
        end
        if (re) begin
            rdata_d = ((WRITE_FIRST != 0) && we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_fifo_out_stage.sv
// Two-entry head/skid output buffer; a load arriving while empty is presented combinationally.
// Zero added latency; the issuer guarantees a load never arrives when full and not popping.
module ram_fifo_out_stage
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;

    always_comb begin
        occ_d  = occ_q + OCC_W'(load) - OCC_W'(pop);
        head_d = head_q;
        skid_d = skid_q;
        if (pop) begin
            if (occ_q == OCC_W'(OUT_STAGE_DEPTH)) begin
                head_d = skid_q;
            end else if (load) begin
                head_d = load_data;
            end
        end else if ((occ_q == '0) && load) begin
            head_d = load_data;
        end
        if (load && (((occ_q == OCC_W'(1)) && !pop) ||
                     ((occ_q == OCC_W'(OUT_STAGE_DEPTH)) && pop))) begin
            skid_d = load_data;
        end
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= '0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    // A read landing in an empty stage falls straight through to the consumer.
    assign occ       = occ_q;
    assign out_valid = (occ_q != '0) || load;
    assign out_data  = ((occ_q == '0) && load) ? load_data : head_q;

endmodule

// File: rtl/ram_fifo_fwft.sv
// FWFT FIFO over a write-first dual-port RAM; push-to-out_valid is one cycle, capacity DEPTH+2.
// in_ready is registered (RAM not full); RAM_FIFO_FWFT_WATERMARK_EN adds the max_count register.
module ram_fifo_fwft
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic [fifo_cnt_w(DEPTH)-1:0]  max_count
);

    localparam int CNT_W  = fifo_cnt_w(DEPTH);
    localparam int AW     = $clog2(DEPTH);
    localparam int NEED_W = OCC_W + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
    logic             rd_pending_q, rd_pending_d;
    logic             in_ready_q, in_ready_d;
    logic             push;
    logic             pop;
    logic             rd_issue;
    logic [NEED_W-1:0] stage_need;
    logic [OCC_W-1:0] stage_occ;
    logic [WIDTH-1:0] ram_rdata;

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        // Slots the output stage will still owe after this cycle's pop.
        stage_need   = NEED_W'(stage_occ) + NEED_W'(rd_pending_q) - NEED_W'(pop);
        rd_issue     = ((ram_cnt_q != '0) || push) &&
                       (stage_need < NEED_W'(OUT_STAGE_DEPTH)) && !flush;
        wr_ptr_d     = push     ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = rd_issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ram_cnt_d    = ram_cnt_q + CNT_W'(push) - CNT_W'(rd_issue);
        rd_pending_d = rd_issue;
        in_ready_d   = (ram_cnt_d != CNT_W'(DEPTH));
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ram_cnt_d    = '0;
            rd_pending_d = 1'b0;
            in_ready_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            rd_pending_q <= rd_pending_d;
            in_ready_q   <= in_ready_d;
        end
    end

    mem_dual_port_rw #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .WRITE_FIRST (1),
        .INIT        (0)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    ram_fifo_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (rd_pending_q),
        .load_data (ram_rdata),
        .pop       (pop),
        .occ       (stage_occ),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    assign in_ready = in_ready_q;
    assign count    = ram_cnt_q + CNT_W'(rd_pending_q) + CNT_W'(stage_occ);

`ifdef RAM_FIFO_FWFT_WATERMARK_EN
    logic [CNT_W-1:0] max_count_q;
    logic [CNT_W-1:0] max_count_d;

    always_comb begin
        max_count_d = (count > max_count_q) ? count : max_count_q;
        if (flush) begin
            max_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_count_q <= '0;
        end else begin
            max_count_q <= max_count_d;
        end
    end

    assign max_count = max_count_q;
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_ram_fifo_fwft.sv
// Directed bench for ram_fifo_fwft (WIDTH=8, DEPTH=4): accepted pushes feed an expected-data
// queue that a negedge monitor drains on every pop; occupancy and flags are checked inline.
module tb_ram_fifo_fwft;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic [2:0] max_count;

    logic [7:0] exp_q[$];
    int         n_pass;
    int         n_total;

    ram_fifo_fwft #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .max_count (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then settle to the falling edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r,
                         input logic f, input logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (f) begin
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(d);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got %0h, expected no output (t=%0t)", out_data, $time);
            end else begin
                check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_max_count", 32'(max_count), 32'd0);

        // Single push, one-cycle fall-through.
        drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
        check("t1_empty_before", 32'(out_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data",  32'(out_data),  32'hA1);
        check("t1_count",     32'(count),     32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t1_data_held", 32'(out_data), 32'hA1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t1_count_empty", 32'(count), 32'd0);
        check("t1_valid_empty", 32'(out_valid), 32'd0);

        // Fill to DEPTH+2, push against full, then drain across the pointer wrap.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        check("t2_count_full",    32'(count),    32'd6);
`ifndef RAM_FIFO_FWFT_WATERMARK_EN
        check("t2_max_count_off", 32'(max_count), 32'd0);
`endif
        drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        check("t2_in_ready_push_pop", 32'(in_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t2_in_ready_reopen", 32'(in_ready), 32'd1);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t2_count_drained", 32'(count), 32'd0);
        check("t2_valid_drained", 32'(out_valid), 32'd0);

        // Streaming: one push and one pop per cycle.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b1);
            if (i > 0) begin
                check("t3_stream_valid", 32'(out_valid), 32'd1);
                check("t3_stream_count", 32'(count),     32'd1);
            end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t3_count_end", 32'(count), 32'd0);

        // Flush with a concurrent push and pop.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b1);
        end
        drive(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t4_flush_count",    32'(count),     32'd0);
        check("t4_flush_valid",    32'(out_valid), 32'd0);
        check("t4_flush_in_ready", 32'(in_ready),  32'd1);
        drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t4_count_end", 32'(count), 32'd0);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t5_count_before", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_count", 32'(count),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t5_first_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t5_count_end", 32'(count), 32'd0);

        // High-water mark: peak of 5, drain, then flush.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t6_max_cleared", 32'(max_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h71 + i), 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t6_count_peak", 32'(count), 32'd5);
        repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t6_count_drained", 32'(count), 32'd0);
`ifdef RAM_FIFO_FWFT_WATERMARK_EN
        check("t6_max_hold", 32'(max_count), 32'd5);
`else
        check("t6_max_off", 32'(max_count), 32'd0);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t6_max_flushed", 32'(max_count), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
